// File: rtl/acc_int_accum_if.sv
// Valid/ready stream bus for the integer accumulator: operand beats in,
// frame sum and beat count out.
`timescale 1ns/1ps

interface acc_int_accum_if #(
  parameter int BWOP = 32,
  parameter int CNTW = 8
);
  logic            in_valid;
  logic            in_ready;
  logic [BWOP-1:0] in_data;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [BWOP-1:0] out_sum;
  logic [CNTW-1:0] out_cnt;

  // Producer of operand beats and consumer of results.
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_cnt
  );

  // The accumulator itself.
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_cnt
  );
endinterface

// File: rtl/acc_int_accum.sv
// Streaming integer accumulator. Folds each accepted beat of a frame into a
// running sum using the lower-bit OR (LOA) addition rule, then holds the sum
// and saturating beat count on the output until the consumer takes them.
// NAPX = 0 gives exact modulo-2^BWOP addition.
`timescale 1ns/1ps

module acc_int_accum #(
  parameter int BWOP = 32,
  parameter int NAPX = 0,
  parameter int CNTW = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  acc_int_accum_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [BWOP-1:0] acc;
  logic [BWOP-1:0] acc_next;
  logic [BWOP-1:0] add_a;
  logic [BWOP-1:0] add_sum;
  logic [CNTW-1:0] cnt;
  logic [CNTW-1:0] cnt_next;
  logic [CNTW-1:0] cnt_inc;
  logic            accept;

  // Handshake outputs depend only on the state register, so in_ready has no
  // path from out_ready and the result is stable for the whole HOLD period.
  assign bus.in_ready  = (state != HOLD);
  assign bus.out_valid = (state == HOLD);
  assign bus.out_sum   = acc;
  assign bus.out_cnt   = cnt;

  assign accept = bus.in_valid & bus.in_ready;

  // The first beat of a frame is added to zero rather than to the register,
  // so a frame never depends on what was left behind by the previous one.
  assign add_a = (state == ACCUM) ? acc : '0;

  // Beat counter sticks at all-ones once it saturates.
  assign cnt_inc = (cnt == {CNTW{1'b1}}) ? cnt : cnt + CNTW'(1);

  generate
    if (NAPX == 0) begin : g_exact
      // Exact addition, carry out of the MSB dropped.
      assign add_sum = add_a + bus.in_data;
    end else begin : g_loa
      logic [NAPX-1:0]      low;
      logic                 cin;
      logic [BWOP-NAPX-1:0] high;

      // Low bits are ORed; only the top low-bit AND feeds a carry upward.
      assign low     = add_a[NAPX-1:0] | bus.in_data[NAPX-1:0];
      assign cin     = add_a[NAPX-1] & bus.in_data[NAPX-1];
      assign high    = add_a[BWOP-1:NAPX] + bus.in_data[BWOP-1:NAPX]
                       + (BWOP-NAPX)'(cin);
      assign add_sum = {high, low};
    end
  endgenerate

  // State, running sum and beat count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic: clear wins over everything, then frame accumulation
  // and the result handshake.
  always_comb begin
    state_next = state;
    acc_next   = acc;
    cnt_next   = cnt;
    if (clr) begin
      state_next = IDLE;
      acc_next   = '0;
      cnt_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc_next   = add_sum;
            cnt_next   = CNTW'(1);
            state_next = bus.in_last ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_next   = add_sum;
            cnt_next   = cnt_inc;
            state_next = bus.in_last ? HOLD : ACCUM;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state_next = IDLE;
            acc_next   = '0;
            cnt_next   = '0;
          end
        end
        default: begin
          state_next = IDLE;
          acc_next   = '0;
          cnt_next   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acc_int_accum.sv
// Self-checking bench for acc_int_accum. Three instances cover exact adds
// (NAPX=0), LOA adds (NAPX=4) and a narrow saturating counter (CNTW=2).
`timescale 1ns/1ps

module tb_acc_int_accum;

  logic clk;
  logic rst_n;

  logic [2:0]  drv_valid;
  logic [2:0]  drv_last;
  logic [2:0]  drv_ready;
  logic [2:0]  drv_clr;
  logic [31:0] drv_data [3];

  wire [2:0]       obs_in_ready;
  wire [2:0]       obs_out_valid;
  wire [2:0][31:0] obs_sum;
  wire [2:0][7:0]  obs_cnt;

  int total;
  int bad;
  logic [31:0] beats[$];

  acc_int_accum_if #(.BWOP(32), .CNTW(8)) bus0 ();
  acc_int_accum_if #(.BWOP(32), .CNTW(8)) bus1 ();
  acc_int_accum_if #(.BWOP(32), .CNTW(2)) bus2 ();

  acc_int_accum #(.BWOP(32), .NAPX(0), .CNTW(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr(drv_clr[0]), .bus(bus0)
  );
  acc_int_accum #(.BWOP(32), .NAPX(4), .CNTW(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(drv_clr[1]), .bus(bus1)
  );
  acc_int_accum #(.BWOP(32), .NAPX(0), .CNTW(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .clr(drv_clr[2]), .bus(bus2)
  );

  assign bus0.in_valid  = drv_valid[0];
  assign bus0.in_last   = drv_last[0];
  assign bus0.in_data   = drv_data[0];
  assign bus0.out_ready = drv_ready[0];
  assign bus1.in_valid  = drv_valid[1];
  assign bus1.in_last   = drv_last[1];
  assign bus1.in_data   = drv_data[1];
  assign bus1.out_ready = drv_ready[1];
  assign bus2.in_valid  = drv_valid[2];
  assign bus2.in_last   = drv_last[2];
  assign bus2.in_data   = drv_data[2];
  assign bus2.out_ready = drv_ready[2];

  assign obs_in_ready  = {bus2.in_ready, bus1.in_ready, bus0.in_ready};
  assign obs_out_valid = {bus2.out_valid, bus1.out_valid, bus0.out_valid};
  assign obs_sum[0]    = bus0.out_sum;
  assign obs_sum[1]    = bus1.out_sum;
  assign obs_sum[2]    = bus2.out_sum;
  assign obs_cnt[0]    = bus0.out_cnt;
  assign obs_cnt[1]    = bus1.out_cnt;
  assign obs_cnt[2]    = {6'd0, bus2.out_cnt};

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int napx_of(input int sel);
    return (sel == 1) ? 4 : 0;
  endfunction

  function automatic int cntw_of(input int sel);
    return (sel == 2) ? 2 : 8;
  endfunction

  // Reference add rule computed with 64-bit arithmetic and masks.
  function automatic logic [31:0] model_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int n);
    longint unsigned la = 64'(a);
    longint unsigned lb = 64'(b);
    longint unsigned mask;
    longint unsigned low;
    longint unsigned cin;
    longint unsigned hi;
    if (n == 0) return 32'((la + lb) & 64'hFFFF_FFFF);
    mask = (64'd1 << n) - 1;
    low  = (la | lb) & mask;
    cin  = ((la & lb) >> (n - 1)) & 64'd1;
    hi   = ((la >> n) + (lb >> n) + cin) << n;
    return 32'((hi | low) & 64'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] model_sum(input int n);
    logic [31:0] s = '0;
    foreach (beats[i]) s = model_add(s, beats[i], n);
    return s;
  endfunction

  function automatic logic [7:0] model_cnt(input int cntw);
    int lim = (1 << cntw) - 1;
    return 8'((beats.size() > lim) ? lim : beats.size());
  endfunction

  // Sends the queued beats to one instance, optionally with idle gaps that
  // carry junk data and a stray in_last to prove they are ignored.
  task automatic drive_frame(input int sel, input bit gaps);
    for (int i = 0; i < beats.size(); i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 1)) begin
          @(negedge clk);
          drv_valid[sel] = 1'b0;
          drv_last[sel]  = 1'($urandom_range(0, 1));
          drv_data[sel]  = $urandom;
        end
      end
      @(negedge clk);
      drv_valid[sel] = 1'b1;
      drv_data[sel]  = beats[i];
      drv_last[sel]  = (i == beats.size() - 1);
    end
    @(negedge clk);
    drv_valid[sel] = 1'b0;
    drv_last[sel]  = 1'b0;
    drv_data[sel]  = $urandom;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    drv_valid = '0;
    drv_last  = '0;
    drv_clr   = '0;
    drv_ready = '1;
    for (int s = 0; s < 3; s++) drv_data[s] = '0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      total++;
      if (obs_in_ready[s] !== 1'b1) begin
        bad++; $display("[TB] FAIL reset_in_ready dut%0d got=%b exp=1", s, obs_in_ready[s]);
      end
      total++;
      if (obs_out_valid[s] !== 1'b0) begin
        bad++; $display("[TB] FAIL reset_out_valid dut%0d got=%b exp=0", s, obs_out_valid[s]);
      end
      total++;
      if (obs_sum[s] !== 32'd0) begin
        bad++; $display("[TB] FAIL reset_sum dut%0d got=%0h exp=0", s, obs_sum[s]);
      end
      total++;
      if (obs_cnt[s] !== 8'd0) begin
        bad++; $display("[TB] FAIL reset_cnt dut%0d got=%0d exp=0", s, obs_cnt[s]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_exact();
    beats = '{32'd1, 32'd2, 32'd3, 32'd4};
    drive_frame(0, 1'b0);
    total++;
    if (obs_out_valid[0] !== 1'b1) begin
      bad++; $display("[TB] FAIL exact_valid got=%b exp=1", obs_out_valid[0]);
    end
    total++;
    if (obs_in_ready[0] !== 1'b0) begin
      bad++; $display("[TB] FAIL exact_in_ready_hold got=%b exp=0", obs_in_ready[0]);
    end
    total++;
    if (obs_sum[0] !== 32'd10) begin
      bad++; $display("[TB] FAIL exact_sum got=%0d exp=10", obs_sum[0]);
    end
    total++;
    if (obs_cnt[0] !== 8'd4) begin
      bad++; $display("[TB] FAIL exact_cnt got=%0d exp=4", obs_cnt[0]);
    end
    @(negedge clk);
    total++;
    if (obs_in_ready[0] !== 1'b1 || obs_out_valid[0] !== 1'b0) begin
      bad++; $display("[TB] FAIL exact_return_idle got ready=%b valid=%b exp ready=1 valid=0",
                      obs_in_ready[0], obs_out_valid[0]);
    end
  endtask

  task automatic test_wrap();
    beats = '{32'hFFFF_FFFF, 32'h0000_0002};
    drive_frame(0, 1'b0);
    total++;
    if (obs_sum[0] !== 32'h0000_0001) begin
      bad++; $display("[TB] FAIL wrap_sum got=%0h exp=1", obs_sum[0]);
    end
    total++;
    if (obs_cnt[0] !== 8'd2) begin
      bad++; $display("[TB] FAIL wrap_cnt got=%0d exp=2", obs_cnt[0]);
    end
    @(negedge clk);
  endtask

  task automatic test_loa();
    beats = '{32'h0F, 32'h01};
    drive_frame(1, 1'b0);
    total++;
    if (obs_sum[1] !== 32'h0F) begin
      bad++; $display("[TB] FAIL loa_no_carry got=%0h exp=f", obs_sum[1]);
    end
    @(negedge clk);
    beats = '{32'h08, 32'h08};
    drive_frame(1, 1'b0);
    total++;
    if (obs_sum[1] !== 32'h18) begin
      bad++; $display("[TB] FAIL loa_carry got=%0h exp=18", obs_sum[1]);
    end
    total++;
    if (obs_cnt[1] !== 8'd2) begin
      bad++; $display("[TB] FAIL loa_cnt got=%0d exp=2", obs_cnt[1]);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_sum;
    beats = '{$urandom, $urandom, $urandom};
    exp_sum = model_sum(0);
    drv_ready[0] = 1'b0;
    drive_frame(0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      total++;
      if (obs_out_valid[0] !== 1'b1 || obs_in_ready[0] !== 1'b0) begin
        bad++; $display("[TB] FAIL bp_hold cyc=%0d got valid=%b ready=%b exp valid=1 ready=0",
                        k, obs_out_valid[0], obs_in_ready[0]);
      end
      total++;
      if (obs_sum[0] !== exp_sum || obs_cnt[0] !== 8'd3) begin
        bad++; $display("[TB] FAIL bp_stable cyc=%0d got sum=%0h cnt=%0d exp sum=%0h cnt=3",
                        k, obs_sum[0], obs_cnt[0], exp_sum);
      end
    end
    drv_ready[0] = 1'b1;
    @(negedge clk);
    total++;
    if (obs_out_valid[0] !== 1'b0 || obs_in_ready[0] !== 1'b1 || obs_cnt[0] !== 8'd0) begin
      bad++; $display("[TB] FAIL bp_idle got valid=%b ready=%b cnt=%0d exp valid=0 ready=1 cnt=0",
                      obs_out_valid[0], obs_in_ready[0], obs_cnt[0]);
    end
  endtask

  task automatic test_saturation();
    beats = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    drive_frame(2, 1'b0);
    total++;
    if (obs_cnt[2] !== 8'd3) begin
      bad++; $display("[TB] FAIL sat_cnt got=%0d exp=3", obs_cnt[2]);
    end
    total++;
    if (obs_sum[2] !== 32'd15) begin
      bad++; $display("[TB] FAIL sat_sum got=%0d exp=15", obs_sum[2]);
    end
    @(negedge clk);
    beats = '{32'd7};
    drive_frame(0, 1'b0);
    total++;
    if (obs_sum[0] !== 32'd7 || obs_cnt[0] !== 8'd1 || obs_out_valid[0] !== 1'b1) begin
      bad++; $display("[TB] FAIL single_beat got sum=%0d cnt=%0d valid=%b exp sum=7 cnt=1 valid=1",
                      obs_sum[0], obs_cnt[0], obs_out_valid[0]);
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    @(negedge clk);
    drv_valid[0] = 1'b1; drv_data[0] = 32'd10; drv_last[0] = 1'b0;
    @(negedge clk);
    drv_data[0] = 32'd20;
    @(negedge clk);
    drv_data[0] = 32'd30; drv_clr[0] = 1'b1;
    @(negedge clk);
    drv_clr[0] = 1'b0; drv_valid[0] = 1'b0;
    total++;
    if (obs_in_ready[0] !== 1'b1 || obs_out_valid[0] !== 1'b0 ||
        obs_sum[0] !== 32'd0 || obs_cnt[0] !== 8'd0) begin
      bad++; $display("[TB] FAIL clr_idle got ready=%b valid=%b sum=%0d cnt=%0d exp 1 0 0 0",
                      obs_in_ready[0], obs_out_valid[0], obs_sum[0], obs_cnt[0]);
    end
    beats = '{32'd5, 32'd6};
    drive_frame(0, 1'b0);
    total++;
    if (obs_sum[0] !== 32'd11 || obs_cnt[0] !== 8'd2) begin
      bad++; $display("[TB] FAIL clr_next_frame got sum=%0d cnt=%0d exp sum=11 cnt=2",
                      obs_sum[0], obs_cnt[0]);
    end
    @(negedge clk);
    drv_ready[0] = 1'b0;
    beats = '{32'd3, 32'd4, 32'd5};
    drive_frame(0, 1'b0);
    total++;
    if (obs_out_valid[0] !== 1'b1) begin
      bad++; $display("[TB] FAIL rst_pre_hold got valid=%b exp=1", obs_out_valid[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (obs_out_valid[0] !== 1'b0 || obs_in_ready[0] !== 1'b1 ||
        obs_sum[0] !== 32'd0 || obs_cnt[0] !== 8'd0) begin
      bad++; $display("[TB] FAIL rst_in_hold got valid=%b ready=%b sum=%0d cnt=%0d exp 0 1 0 0",
                      obs_out_valid[0], obs_in_ready[0], obs_sum[0], obs_cnt[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drv_ready[0] = 1'b1;
  endtask

  task automatic test_random();
    for (int t = 0; t < 60; t++) begin
      int sel = int'($urandom_range(0, 2));
      int len = int'($urandom_range(1, 6));
      int stall = int'($urandom_range(0, 3));
      logic [31:0] exp_sum;
      logic [7:0]  exp_cnt;
      beats.delete();
      for (int i = 0; i < len; i++) beats.push_back($urandom);
      exp_sum = model_sum(napx_of(sel));
      exp_cnt = model_cnt(cntw_of(sel));
      drv_ready[sel] = (stall == 0);
      drive_frame(sel, 1'b1);
      repeat (stall) @(negedge clk);
      total++;
      if (obs_out_valid[sel] !== 1'b1 || obs_sum[sel] !== exp_sum || obs_cnt[sel] !== exp_cnt) begin
        bad++; $display("[TB] FAIL rand_frame t=%0d dut%0d got valid=%b sum=%0h cnt=%0d exp valid=1 sum=%0h cnt=%0d",
                        t, sel, obs_out_valid[sel], obs_sum[sel], obs_cnt[sel], exp_sum, exp_cnt);
      end
      drv_ready[sel] = 1'b1;
      @(negedge clk);
      total++;
      if (obs_out_valid[sel] !== 1'b0 || obs_in_ready[sel] !== 1'b1) begin
        bad++; $display("[TB] FAIL rand_idle t=%0d dut%0d got valid=%b ready=%b exp valid=0 ready=1",
                        t, sel, obs_out_valid[sel], obs_in_ready[sel]);
      end
    end
  endtask

  // Runs every scenario in order, then prints the summary.
  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_exact();
    test_wrap();
    test_loa();
    test_backpressure();
    test_saturation();
    test_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
